// File: rtl/nodemerge_arbiter_pkg.sv
// Shared types and constants for the node-merge arbiter and its round-robin helper.
package nodemerge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int NODE_PORTS = 4;
  localparam int CTRL_W     = 3;
  localparam int FLIT_W     = 11;

  // Scalar reference of the round-robin search for a 4-port node; returns ptr when nothing is requesting.
  function automatic logic [1:0] rr_pick(input logic [NODE_PORTS-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = NODE_PORTS - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/nodemerge_arbiter_if.sv
// Control/grant channel between the node-merge arbiter (master) and the merge datapath (slave).
interface nodemerge_arbiter_if #(
  parameter int N     = 4,
  parameter int SEL_W = 3
);

  logic [N-1:0]     req;
  logic             ctrl_valid;
  logic             ctrl_ready;
  logic [SEL_W-1:0] ctrl_data;
  logic [N-1:0]     grant;
  logic             flit_fire;
  logic             flit_tail;
  logic             err_timeout;

  modport master (
    input  req, ctrl_ready, flit_fire, flit_tail,
    output ctrl_valid, ctrl_data, grant, err_timeout
  );

  modport slave (
    output req, ctrl_ready, flit_fire, flit_tail,
    input  ctrl_valid, ctrl_data, grant, err_timeout
  );

endinterface

// File: rtl/nodemerge_arbiter_rr_priority_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping N-1 -> 0.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N);

  logic [PTR_W:0] cand;

  // Walk offsets from high to low so the closest requester to ptr is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (req[cand[PTR_W-1:0]]) begin
        idx   = cand[PTR_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nodemerge_arbiter.sv
// Packet-level round-robin arbiter driving the 4-input merge control channel.
// Optional per-input grant and timeout counters are built when NODEMERGE_ARB_CNT_EN is defined.
module nodemerge_arbiter
  import nodemerge_pkg::*;
#(
  parameter int N        = NODE_PORTS,
  parameter int SEL_W    = CTRL_W,
  parameter int MAX_HOLD = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  nodemerge_arbiter_if.master bus
`ifdef NODEMERGE_ARB_CNT_EN
  ,
  output logic [N-1:0][15:0]  grant_cnt,
  output logic [7:0]          timeout_cnt
`endif
);

  localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] winner_q, winner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic             tail_fire;
  logic             handshake;
  logic             timeout_hit;

`ifdef NODEMERGE_ARB_CNT_EN
  logic [N-1:0][15:0] grant_cnt_q, grant_cnt_d;
  logic [7:0]         timeout_cnt_q, timeout_cnt_d;
`endif

  rr_priority_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign tail_fire = bus.flit_fire && bus.flit_tail;
  assign handshake = (state_q == ISSUE) && bus.ctrl_ready;

  // A tail in the same cycle as the limit ends the packet normally, so it masks the timeout.
  if (MAX_HOLD > 0) begin : g_wdog
    assign timeout_hit = (state_q == HOLD) && (hold_cnt_q == HOLD_W'(MAX_HOLD)) && !tail_fire;
  end else begin : g_no_wdog
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      winner_q   <= '0;
      hold_cnt_q <= '0;
`ifdef NODEMERGE_ARB_CNT_EN
      grant_cnt_q   <= '0;
      timeout_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef NODEMERGE_ARB_CNT_EN
      grant_cnt_q   <= grant_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = ISSUE;
          winner_d = pick_idx;
        end
      end
      ISSUE: begin
        if (handshake) begin
          state_d    = HOLD;
          ptr_d      = (winner_q == PTR_W'(N - 1)) ? '0 : winner_q + PTR_W'(1);
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (tail_fire || timeout_hit) begin
          state_d = IDLE;
        end else if (MAX_HOLD > 0) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ctrl_valid                = (state_q == ISSUE);
    bus.ctrl_data                 = '0;
    bus.ctrl_data[PTR_W-1:0]      = winner_q;
    bus.grant                     = '0;
    if (state_q == HOLD) bus.grant[winner_q] = 1'b1;
    bus.err_timeout               = timeout_hit;
  end

`ifdef NODEMERGE_ARB_CNT_EN
  // Both counters saturate rather than wrap so a long run never reads back as few events.
  always_comb begin
    grant_cnt_d   = grant_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (handshake && (grant_cnt_q[winner_q] != 16'hFFFF))
      grant_cnt_d[winner_q] = grant_cnt_q[winner_q] + 16'd1;
    if (timeout_hit && (timeout_cnt_q != 8'hFF))
      timeout_cnt_d = timeout_cnt_q + 8'd1;
  end

  assign grant_cnt   = grant_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`endif

  flit_fire_needs_grant: assert property (@(posedge CLK) disable iff (RESET)
    bus.flit_fire |-> (bus.grant != '0));

endmodule

// File: tb/tb_nodemerge_arbiter.sv
// Directed bench for nodemerge_arbiter: vector tables for single-cycle behaviour plus hand sequences for stalls, watchdog and reset.
module tb_nodemerge_arbiter;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  nodemerge_arbiter_if #(.N(4), .SEL_W(3)) nm_if ();

`ifdef NODEMERGE_ARB_CNT_EN
  logic [3:0][15:0] grant_cnt;
  logic [7:0]       timeout_cnt;
`endif

  nodemerge_arbiter #(.N(4), .SEL_W(3), .MAX_HOLD(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (nm_if)
`ifdef NODEMERGE_ARB_CNT_EN
    ,
    .grant_cnt   (grant_cnt),
    .timeout_cnt (timeout_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       fire;
    logic       tail;
    logic       exp_valid;
    logic [2:0] exp_data;
    logic [3:0] exp_grant;
    logic       exp_err;
  } vec_t;

  vec_t vec_q[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setInputs(input logic [3:0] req, input logic rdy, input logic fire, input logic tail);
    nm_if.req        = req;
    nm_if.ctrl_ready = rdy;
    nm_if.flit_fire  = fire;
    nm_if.flit_tail  = tail;
  endtask

  task automatic doReset();
    RESET = 1'b1;
    setInputs(4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // One row = inputs for the coming edge, outputs expected from the previous edge.
  task automatic applyStimulus(input string tag);
    foreach (vec_q[i]) begin
      setInputs(vec_q[i].req, vec_q[i].rdy, vec_q[i].fire, vec_q[i].tail);
      #1;
      checkOutput($sformatf("%s[%0d].valid", tag, i), 32'(nm_if.ctrl_valid), 32'(vec_q[i].exp_valid));
      if (vec_q[i].exp_valid)
        checkOutput($sformatf("%s[%0d].data", tag, i), 32'(nm_if.ctrl_data), 32'(vec_q[i].exp_data));
      checkOutput($sformatf("%s[%0d].grant", tag, i), 32'(nm_if.grant), 32'(vec_q[i].exp_grant));
      checkOutput($sformatf("%s[%0d].err", tag, i), 32'(nm_if.err_timeout), 32'(vec_q[i].exp_err));
      tick();
    end
    setInputs(4'b0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, 32'(nm_if.ctrl_valid), 32'd0);
    checkOutput({tag, ".grant"}, 32'(nm_if.grant), 32'd0);
    checkOutput({tag, ".err"}, 32'(nm_if.err_timeout), 32'd0);
  endtask

  initial begin
    int order[10];
    int w;
    checks = 0;
    errors = 0;
    doReset();

    #1;
    checkIdle("reset");
    checkOutput("reset.data", 32'(nm_if.ctrl_data), 32'd0);

    vec_q.delete();
    vec_q.push_back(vec_t'{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0});
    vec_q.push_back(vec_t'{4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b0});
    vec_q.push_back(vec_t'{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0100, 1'b0});
    vec_q.push_back(vec_t'{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b0});
    vec_q.push_back(vec_t'{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0});
    applyStimulus("single");

    // All inputs requesting, single-flit packets: grants rotate 0,1,2,3,...
    doReset();
    order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    vec_q.delete();
    for (int k = 0; k < 10; k++) begin
      w = order[k];
      vec_q.push_back(vec_t'{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0});
      vec_q.push_back(vec_t'{4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 3'(w), 4'b0000, 1'b0});
      vec_q.push_back(vec_t'{4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'(1 << w), 1'b0});
    end
    applyStimulus("rr");
`ifdef NODEMERGE_ARB_CNT_EN
    checkOutput("grant_cnt0", 32'(grant_cnt[0]), 32'd3);
    checkOutput("grant_cnt1", 32'(grant_cnt[1]), 32'd3);
    checkOutput("grant_cnt2", 32'(grant_cnt[2]), 32'd2);
    checkOutput("grant_cnt3", 32'(grant_cnt[3]), 32'd2);
`endif

    // Back-pressure: token must stay put while ready is low, even after req drops.
    doReset();
    setInputs(4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      setInputs(4'b0000, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("stall[%0d].valid", i), 32'(nm_if.ctrl_valid), 32'd1);
      checkOutput($sformatf("stall[%0d].data", i), 32'(nm_if.ctrl_data), 32'd1);
      checkOutput($sformatf("stall[%0d].grant", i), 32'(nm_if.grant), 32'd0);
      tick();
    end
    setInputs(4'b0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stall_hs.valid", 32'(nm_if.ctrl_valid), 32'd1);
    checkOutput("stall_hs.data", 32'(nm_if.ctrl_data), 32'd1);
    tick();
    checkOutput("stall_hold.valid", 32'(nm_if.ctrl_valid), 32'd0);
    checkOutput("stall_hold.grant", 32'(nm_if.grant), 32'b0010);
    setInputs(4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    setInputs(4'b0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkIdle("stall_done");

    // Watchdog: no tail for 8 HOLD cycles forces release with a one-cycle error.
    setInputs(4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      setInputs(4'b0000, 1'b1, (k == 2 || k == 3), 1'b0);
      #1;
      checkOutput($sformatf("wdog[%0d].grant", k), 32'(nm_if.grant), 32'b0100);
      checkOutput($sformatf("wdog[%0d].err", k), 32'(nm_if.err_timeout), 32'd0);
      tick();
    end
    setInputs(4'b0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("wdog[8].err", 32'(nm_if.err_timeout), 32'd1);
    checkOutput("wdog[8].grant", 32'(nm_if.grant), 32'b0100);
    tick();
    checkIdle("wdog_after");
`ifdef NODEMERGE_ARB_CNT_EN
    checkOutput("timeout_cnt", 32'(timeout_cnt), 32'd1);
`endif

    // Tail landing on the limit cycle wins over the timeout.
    setInputs(4'b1000, 1'b1, 1'b0, 1'b0);
    tick();
    #1;
    checkOutput("tail8_issue.data", 32'(nm_if.ctrl_data), 32'd3);
    tick();
    for (int k = 0; k < 8; k++) begin
      setInputs(4'b0000, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("tail8[%0d].err", k), 32'(nm_if.err_timeout), 32'd0);
      tick();
    end
    setInputs(4'b0000, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("tail8[8].err", 32'(nm_if.err_timeout), 32'd0);
    checkOutput("tail8[8].grant", 32'(nm_if.grant), 32'b1000);
    tick();
    setInputs(4'b0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkIdle("tail8_after");
`ifdef NODEMERGE_ARB_CNT_EN
    checkOutput("timeout_cnt_tail", 32'(timeout_cnt), 32'd1);
`endif

    // Reset in the middle of a held packet.
    setInputs(4'b0010, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("midrst_hold.grant", 32'(nm_if.grant), 32'b0010);
    setInputs(4'b1000, 1'b1, 1'b0, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    checkIdle("midrst");
    checkOutput("midrst.data", 32'(nm_if.ctrl_data), 32'd0);
    tick();
    checkOutput("midrst_issue.valid", 32'(nm_if.ctrl_valid), 32'd1);
    checkOutput("midrst_issue.data", 32'(nm_if.ctrl_data), 32'd3);
    tick();
    checkOutput("midrst_hold2.grant", 32'(nm_if.grant), 32'b1000);
    setInputs(4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    setInputs(4'b0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkIdle("midrst_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nodemerge_arbiter.md
Name: nodemerge_arbiter

Overview:
- Packet-level round-robin arbiter that generates the select/control token stream for a 4-input node merge. Replaces the random control source used at the merge today.
- Watches per-input request flags and issues a winner index on a valid/ready control channel. Holds the grant until the granted packet's tail flit leaves the merge output.
- Sits beside the merge inside a NoC router node. Runs in the synchronous RTL domain, ahead of the cosim wrapper.

Parameters:
- N, 4, number of requesters (merge inputs); fixed at 4 for this node, kept generic for the round-robin logic.
- SEL_W, 3, width of the control token (matches the merge control_in width; upper bits zero).
- MAX_HOLD, 64, max cycles in HOLD without a tail flit before forced release; 0 disables the watchdog.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- req  in  N  per-input "packet head waiting" flags; level-sensitive
- ctrl_valid  out  1  control token valid
- ctrl_ready  in  1  merge accepts control token
- ctrl_data  out  SEL_W  winner index 0..N-1, zero-extended
- grant  out  N  one-hot, identifies the input owning the merge
- flit_fire  in  1  merge output handshake completed this cycle
- flit_tail  in  1  tail bit of the flit in the current flit_fire
- err_timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset: applied at a CLK edge with RESET=1, in any state including mid-packet.
  - State -> IDLE; ptr -> 0.
  - Outputs: ctrl_valid=0, ctrl_data=0, grant=0, err_timeout=0.
  - Hold counter -> 0.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - If req != 0, winner = first set bit searching from ptr upward, with wrap-around (N-1 -> 0).
  - Next cycle: ISSUE, ctrl_valid=1, ctrl_data=winner.
  - Latency from req to ctrl_valid: 1 cycle. With req=0, stay in IDLE.
- ISSUE:
  - ctrl_valid and ctrl_data stay stable until ctrl_valid&&ctrl_ready.
  - No retraction: req deasserting here does not cancel the token.
  - On handshake: ptr <= (winner+1) mod N; next state HOLD; grant=onehot(winner) from the next cycle; ctrl_valid=0.
- HOLD:
  - On flit_fire&&flit_tail: next state IDLE, grant=0 next cycle.
  - A single-flit packet (tail on the first flit) is legal.
  - New arbitration starts in IDLE the cycle after release. Minimum packet-to-packet control spacing is 3 cycles.
- Watchdog (MAX_HOLD>0):
  - Counter clears on HOLD entry and increments every HOLD cycle without a tail.
  - When it reaches MAX_HOLD: next state IDLE, grant=0, err_timeout=1 for one cycle.
  - If a tail and the timeout occur in the same cycle, the tail wins: no error.
- flit_fire outside HOLD is ignored. Simulation assertion: flit_fire only while grant!=0.
- Fairness: the input just served has lowest priority next round. With all req=1, the grant order is 0,1,2,3,0,...
- ctrl_data upper SEL_W-log2(N) bits are always 0.

Optional Feature:
- Macro: NODEMERGE_ARB_CNT_EN.
- Defined:
  - Adds output grant_cnt [N][16], one counter per input.
  - Each counter increments on that input's control handshake and saturates at 16'hFFFF.
  - Counters clear on RESET.
  - Adds output timeout_cnt [8], saturating, counting err_timeout pulses.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package nodemerge_pkg:
  - arb_state_t enum {IDLE, ISSUE, HOLD}.
  - Constants NODE_PORTS=4, CTRL_W=3, FLIT_W=11.
  - Function rr_pick(req, ptr) returning the index.
- Sub-module rr_priority_pick: combinational round-robin search, reused by other router arbiters. Everything else (FSM, ptr, watchdog, counters) stays in nodemerge_arbiter.

Test Plan:
- Reset, then req=4'b0100, ctrl_ready=1 -> ctrl_valid=1 with ctrl_data=2 one cycle after req; grant=4'b0100 after the handshake.
- req=4'b1111 constantly, 1-flit packets (flit_fire&&flit_tail one cycle after grant) -> ctrl_data sequence 0,1,2,3,0,1.
- ctrl_ready held 0 for 5 cycles while req drops to 0 -> ctrl_valid and ctrl_data=1 stable all 5 cycles; handshake on cycle 6; HOLD entered.
- MAX_HOLD=8, grant held with no tail -> err_timeout pulses exactly 8 cycles after HOLD entry, grant=0 next cycle; tail on cycle 8 instead -> no pulse.
- RESET asserted mid-HOLD with req=4'b1000 -> grant=0, ctrl_valid=0 next cycle; after release, first winner is 3 (ptr=0 search, only req3 set).
- With NODEMERGE_ARB_CNT_EN, 10 packets, all req=1 -> grant_cnt = {3,3,2,2} for inputs 0..3.
